// File: rtl/pong_pkg.sv
// Shared encodings for the Pong game-flow sequencer: FSM states and winner codes.
package pong_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE       = 3'd0,
        SERVE_WAIT = 3'd1,
        PLAY       = 3'd2,
        POINT      = 3'd3,
        OVER       = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        P1   = 2'b01,
        P2   = 2'b10,
        DRAW = 2'b11
    } winner_t;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Signal bundle between the game-flow sequencer and its surroundings
// (start button, ball FSM, countdown timer, displays).
interface game_flow_ctrl_if #(
    parameter int SCORE_W = 3
);
    logic                        i_start;
    logic                        i_tick_1hz;
    logic                        i_miss1;
    logic                        i_miss2;
    logic                        i_time_up;
    logic                        o_stop;
    logic                        o_serve;
    logic                        o_serve_dir;
    logic                        o_timer_run;
    logic                        o_timer_load;
    logic [SCORE_W-1:0]          o_score1;
    logic [SCORE_W-1:0]          o_score2;
    logic [1:0]                  o_winner;
    logic [pong_pkg::STATE_W-1:0] o_game_state;

    modport slave (
        input  i_start, i_tick_1hz, i_miss1, i_miss2, i_time_up,
        output o_stop, o_serve, o_serve_dir, o_timer_run, o_timer_load,
        output o_score1, o_score2, o_winner, o_game_state
    );

    modport master (
        output i_start, i_tick_1hz, i_miss1, i_miss2, i_time_up,
        input  o_stop, o_serve, o_serve_dir, o_timer_run, o_timer_load,
        input  o_score1, o_score2, o_winner, o_game_state
    );
endinterface

// File: rtl/game_flow_ctrl_tick_counter.sv
// Serve-delay counter: counts enabled ticks and flags the tick that completes
// SERVE_TICKS, wrapping back to zero on that tick.
module tick_counter #(
    parameter int SERVE_TICKS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_tick,
    output logic o_done
);
    localparam int            CW   = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(SERVE_TICKS - 1);

    logic [CW-1:0] r_count;

    assign o_done = i_tick && (r_count == LAST);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_tick) begin
            r_count <= o_done ? '0 : r_count + 1'b1;
        end
    end
endmodule

// File: rtl/game_flow_ctrl.sv
// Pong match lifecycle FSM: serve delay, rally, scoring and match-over, with
// every output registered so the datapath and displays see clean levels.
module game_flow_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 7,
    parameter int SCORE_W     = 3,
    parameter int SERVE_TICKS = 2
) (
    input  logic             clk,
    input  logic             rst,
    game_flow_ctrl_if.slave  bus
);
    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    state_t             r_state, w_next_state;
    logic               r_start_q;
    logic               r_stop, r_serve, r_dir, r_run, r_load;
    logic               w_serve, w_dir, w_load;
    logic [SCORE_W-1:0] r_score1, r_score2, w_score1, w_score2;
    winner_t            r_winner, w_winner;
    logic               w_start_rise;
    logic               w_serve_done;
    logic               w_in_wait;

    function automatic winner_t judge(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
        if (a > b)      return P1;
        else if (b > a) return P2;
        else            return DRAW;
    endfunction

    assign w_start_rise = bus.i_start & ~r_start_q;
    assign w_in_wait    = (r_state == SERVE_WAIT);

    tick_counter #(
        .SERVE_TICKS (SERVE_TICKS)
    ) u_tick_counter (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (~w_in_wait),
        .i_tick (bus.i_tick_1hz & w_in_wait),
        .o_done (w_serve_done)
    );

    // Next-state and next-output logic; stop/timer_run follow the next state.
    always_comb begin
        w_next_state = r_state;
        w_score1     = r_score1;
        w_score2     = r_score2;
        w_winner     = r_winner;
        w_dir        = r_dir;
        w_serve      = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            IDLE, OVER: begin
                if (w_start_rise) begin
                    w_next_state = SERVE_WAIT;
                    w_score1     = '0;
                    w_score2     = '0;
                    w_winner     = NONE;
                    w_dir        = 1'b0;
                    w_load       = 1'b1;
                end
            end
            SERVE_WAIT: begin
                if (w_serve_done) begin
                    w_next_state = PLAY;
                    w_serve      = 1'b1;
                end
            end
            PLAY: begin
                if (bus.i_time_up) begin
                    w_next_state = OVER;
                    w_winner     = judge(r_score1, r_score2);
                end else if (bus.i_miss1 && bus.i_miss2) begin
                    w_next_state = POINT;
                end else if (bus.i_miss1) begin
                    w_next_state = POINT;
                    w_dir        = 1'b0;
                    w_score2     = (r_score2 == WIN) ? r_score2 : r_score2 + 1'b1;
                end else if (bus.i_miss2) begin
                    w_next_state = POINT;
                    w_dir        = 1'b1;
                    w_score1     = (r_score1 == WIN) ? r_score1 : r_score1 + 1'b1;
                end
            end
            POINT: begin
                if (r_score1 == WIN || r_score2 == WIN) begin
                    w_next_state = OVER;
                    w_winner     = judge(r_score1, r_score2);
                end else begin
                    w_next_state = SERVE_WAIT;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_score1     = '0;
                w_score2     = '0;
                w_winner     = NONE;
                w_dir        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_start_q <= 1'b1;
            r_stop    <= 1'b1;
            r_serve   <= 1'b0;
            r_dir     <= 1'b0;
            r_run     <= 1'b0;
            r_load    <= 1'b0;
            r_score1  <= '0;
            r_score2  <= '0;
            r_winner  <= NONE;
        end else begin
            r_state   <= w_next_state;
            r_start_q <= bus.i_start;
            r_stop    <= (w_next_state != PLAY);
            r_serve   <= w_serve;
            r_dir     <= w_dir;
            r_run     <= (w_next_state == PLAY);
            r_load    <= w_load;
            r_score1  <= w_score1;
            r_score2  <= w_score2;
            r_winner  <= w_winner;
        end
    end

    assign bus.o_stop       = r_stop;
    assign bus.o_serve      = r_serve;
    assign bus.o_serve_dir  = r_dir;
    assign bus.o_timer_run  = r_run;
    assign bus.o_timer_load = r_load;
    assign bus.o_score1     = r_score1;
    assign bus.o_score2     = r_score2;
    assign bus.o_winner     = r_winner;
    assign bus.o_game_state = r_state;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Vector-table bench for game_flow_ctrl: each record drives one cycle of inputs
// and states the full output bundle expected after the following clock edge.
module tb_game_flow_ctrl;
    localparam int SCORE_W = 3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_POINT = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    // Input nibble order: {rst, start, tick, miss1, miss2, timeUp}
    typedef struct {
        string      name;
        int         gap;
        logic [5:0] in;
        logic [2:0] expState;
        logic       expServe;
        logic       expLoad;
        logic       expDir;
        logic [2:0] expS1;
        logic [2:0] expS2;
        logic [1:0] expWin;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    game_flow_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

    game_flow_ctrl #(
        .WIN_SCORE   (7),
        .SCORE_W     (SCORE_W),
        .SERVE_TICKS (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_t vecs[$];
    sb_t  expQ[$];
    int   vectorCount = 0;
    int   missCount   = 0;
    logic lastStart   = 1'b0;

    function automatic logic [15:0] packOut(
        input logic [2:0] st, input logic stop, input logic serve, input logic dir,
        input logic run, input logic load, input logic [2:0] s1, input logic [2:0] s2,
        input logic [1:0] win);
        return {st, stop, serve, dir, run, load, s1, s2, win};
    endfunction

    function automatic string fmt(input logic [15:0] p);
        return $sformatf("st=%0d stop=%b serve=%b dir=%b run=%b load=%b s1=%0d s2=%0d win=%b",
                         p[15:13], p[12], p[11], p[10], p[9], p[8], p[7:5], p[4:2], p[1:0]);
    endfunction

    task automatic addVec(input string name, input int gap, input logic [5:0] in,
                          input logic [2:0] st, input logic serve, input logic load,
                          input logic dir, input logic [2:0] s1, input logic [2:0] s2,
                          input logic [1:0] win);
        vec_t v;
        v.name = name; v.gap = gap; v.in = in; v.expState = st;
        v.expServe = serve; v.expLoad = load; v.expDir = dir;
        v.expS1 = s1; v.expS2 = s2; v.expWin = win;
        vecs.push_back(v);
    endtask

    // Two ticks a few cycles apart: counter advances, then the serve fires.
    task automatic serveSeq(input logic dir, input int s1, input int s2);
        addVec("serveTickA", 3, 6'b011000, S_WAIT, 1'b0, 1'b0, dir, 3'(s1), 3'(s2), 2'b00);
        addVec("serveTickB", 3, 6'b011000, S_PLAY, 1'b1, 1'b0, dir, 3'(s1), 3'(s2), 2'b00);
    endtask

    task automatic pointSeq(input string name, input logic [5:0] in, input logic dir,
                            input int s1, input int s2);
        addVec(name, 0, in, S_POINT, 1'b0, 1'b0, dir, 3'(s1), 3'(s2), 2'b00);
        addVec("pointToWait", 0, 6'b010000, S_WAIT, 1'b0, 1'b0, dir, 3'(s1), 3'(s2), 2'b00);
    endtask

    task automatic driveInputs(input logic [5:0] in);
        rst            = in[5];
        bus.i_start    = in[4];
        bus.i_tick_1hz = in[3];
        bus.i_miss1    = in[2];
        bus.i_miss2    = in[1];
        bus.i_time_up  = in[0];
    endtask

    task automatic applyStimulus(input vec_t v);
        sb_t e;
        for (int g = 0; g < v.gap; g++) begin
            driveInputs({1'b0, lastStart, 4'b0000});
            @(posedge clk);
            #1;
        end
        driveInputs(v.in);
        lastStart = v.in[4];
        e.name = v.name;
        e.exp  = packOut(v.expState, v.expState != S_PLAY, v.expServe, v.expDir,
                         v.expState == S_PLAY, v.expLoad, v.expS1, v.expS2, v.expWin);
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        sb_t         e;
        logic [15:0] act;
        @(posedge clk);
        #1;
        vectorCount++;
        if (expQ.size() == 0) begin
            missCount++;
            $display("[TB] FAIL scoreboard: got output with no expected entry queued");
        end else begin
            e   = expQ.pop_front();
            act = packOut(bus.o_game_state, bus.o_stop, bus.o_serve, bus.o_serve_dir,
                          bus.o_timer_run, bus.o_timer_load, bus.o_score1, bus.o_score2,
                          bus.o_winner);
            if (act !== e.exp) begin
                missCount++;
                $display("[TB] FAIL %s: got %s, expected %s", e.name, fmt(act), fmt(e.exp));
            end
        end
    endtask

    initial begin
        driveInputs(6'b000000);

        // Reset with start held, then idle behaviour and first serve
        addVec("rst1",          0,   6'b110000, S_IDLE, 0, 0, 0, 0, 0, 2'b00);
        addVec("rst2",          0,   6'b110000, S_IDLE, 0, 0, 0, 0, 0, 2'b00);
        addVec("rstRelHeld",    0,   6'b010000, S_IDLE, 0, 0, 0, 0, 0, 2'b00);
        addVec("startLow",      0,   6'b000000, S_IDLE, 0, 0, 0, 0, 0, 2'b00);
        addVec("idleIgnore",    5,   6'b001111, S_IDLE, 0, 0, 0, 0, 0, 2'b00);
        addVec("startRise",     0,   6'b010000, S_WAIT, 0, 1, 0, 0, 0, 2'b00);
        addVec("waitHold",      0,   6'b010000, S_WAIT, 0, 0, 0, 0, 0, 2'b00);
        addVec("tick1",         100, 6'b011000, S_WAIT, 0, 0, 0, 0, 0, 2'b00);
        addVec("tick2",         100, 6'b011000, S_PLAY, 1, 0, 0, 0, 0, 2'b00);
        addVec("playHold",      0,   6'b010000, S_PLAY, 0, 0, 0, 0, 0, 2'b00);
        addVec("playStartLow",  0,   6'b000000, S_PLAY, 0, 0, 0, 0, 0, 2'b00);
        addVec("playStartRise", 0,   6'b010000, S_PLAY, 0, 0, 0, 0, 0, 2'b00);

        // Player 1 misses seven times: player 2 wins
        for (int k = 1; k <= 7; k++) begin
            addVec("miss1Point", 0, 6'b010100, S_POINT, 0, 0, 0, 3'd0, 3'(k), 2'b00);
            if (k < 7) begin
                addVec("pointToWait", 0, 6'b010000, S_WAIT, 0, 0, 0, 3'd0, 3'(k), 2'b00);
                if (k == 1)
                    addVec("waitMissIgnore", 0, 6'b010110, S_WAIT, 0, 0, 0, 3'd0, 3'(k), 2'b00);
                serveSeq(1'b0, 0, k);
            end
        end
        addVec("pointToOver",   0, 6'b010000, S_OVER, 0, 0, 0, 0, 7, 2'b10);
        addVec("overIgnore",    3, 6'b011111, S_OVER, 0, 0, 0, 0, 7, 2'b10);

        // Restart, simultaneous miss, ignored start, then 3:3 and time-up draw
        addVec("overStartLow",  0, 6'b000000, S_OVER, 0, 0, 0, 0, 7, 2'b10);
        addVec("restart",       0, 6'b010000, S_WAIT, 0, 1, 0, 0, 0, 2'b00);
        serveSeq(1'b0, 0, 0);
        pointSeq("bothMiss", 6'b010110, 1'b0, 0, 0);
        addVec("waitStartLow",  0, 6'b000000, S_WAIT, 0, 0, 0, 0, 0, 2'b00);
        addVec("waitStartRise", 0, 6'b010000, S_WAIT, 0, 0, 0, 0, 0, 2'b00);
        serveSeq(1'b0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            pointSeq("miss2Point", 6'b010010, 1'b1, i, i - 1);
            serveSeq(1'b1, i, i - 1);
            pointSeq("miss1Point", 6'b010100, 1'b0, i, i);
            serveSeq(1'b0, i, i);
        end
        addVec("timeUpDraw",    0, 6'b010001, S_OVER, 0, 0, 0, 3, 3, 2'b11);

        // time_up beats a simultaneous miss; player 1 ahead wins
        addVec("overStartLow2", 0, 6'b000000, S_OVER, 0, 0, 0, 3, 3, 2'b11);
        addVec("restart2",      0, 6'b010000, S_WAIT, 0, 1, 0, 0, 0, 2'b00);
        serveSeq(1'b0, 0, 0);
        pointSeq("miss2Point", 6'b010010, 1'b1, 1, 0);
        serveSeq(1'b1, 1, 0);
        addVec("timeUpMiss2",   0, 6'b010011, S_OVER, 0, 0, 1, 1, 0, 2'b01);

        // Reset mid-rally with score1=4, and reset coinciding with the serve tick
        addVec("overStartLow3", 0, 6'b000000, S_OVER, 0, 0, 1, 1, 0, 2'b01);
        addVec("restart3",      0, 6'b010000, S_WAIT, 0, 1, 0, 0, 0, 2'b00);
        serveSeq(1'b0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            pointSeq("miss2Point", 6'b010010, 1'b1, i, 0);
            serveSeq(1'b1, i, 0);
        end
        addVec("rstInPlay",     0, 6'b110000, S_IDLE, 0, 0, 0, 0, 0, 2'b00);
        addVec("afterRstHeld",  0, 6'b010000, S_IDLE, 0, 0, 0, 0, 0, 2'b00);
        addVec("idleStartLow",  0, 6'b000000, S_IDLE, 0, 0, 0, 0, 0, 2'b00);
        addVec("restart4",      0, 6'b010000, S_WAIT, 0, 1, 0, 0, 0, 2'b00);
        addVec("waitTickA",     3, 6'b011000, S_WAIT, 0, 0, 0, 0, 0, 2'b00);
        addVec("rstOnTick",     3, 6'b111000, S_IDLE, 0, 0, 0, 0, 0, 2'b00);
        addVec("idleEnd",       0, 6'b000000, S_IDLE, 0, 0, 0, 0, 0, 2'b00);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        if (expQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL scoreboard: %0d expected entries left unchecked", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Game-flow sequencer for the Pong datapath. It owns the match lifecycle: idle, serve delay, rally, point scoring, match over. It drives the ball/paddle datapath freeze (stop), the serve reload pulse and the countdown-timer run/load controls, and holds both scores and the winner for the dot-matrix and seven-segment displays. It sits between the keypad/start input, the ball state machine (miss1/miss2 source) and the countdown timer (time_up source).

Parameters:
WIN_SCORE, 7, points needed to win; must satisfy 1 <= WIN_SCORE <= 2^SCORE_W-1
SCORE_W, 3, width of each score register
SERVE_TICKS, 2, number of tick_1hz pulses waited in SERVE_WAIT before each serve (>=1)

Ports:
clk  in  1  system clock; the only clock
rst  in  1  reset, synchronous, active-high
start  in  1  debounced start button level; rising edge detected internally
tick_1hz  in  1  single-cycle enable pulse at 1 Hz, synchronous to clk
miss1  in  1  ball passed paddle 1 (player 2 scores)
miss2  in  1  ball passed paddle 2 (player 1 scores)
time_up  in  1  countdown timer at 0:00 (level)
stop  out  1  freeze ball and paddles
serve  out  1  one-cycle pulse: datapath reloads ball at centre
serve_dir  out  1  0 = serve toward player 1, 1 = toward player 2
timer_run  out  1  countdown timer enable
timer_load  out  1  one-cycle pulse: timer reloads its full match time
score1  out  SCORE_W  player 1 score
score2  out  SCORE_W  player 2 score
winner  out  2  00 none, 01 player 1, 10 player 2, 11 draw
game_state  out  3  current state encoding (debug/display)

Behaviour:
- All outputs registered. Reset values: state IDLE, stop=1, serve=0, serve_dir=0, timer_run=0, timer_load=0, score1=score2=0, winner=00, delay counter=0. The start edge-detect flop resets to 1, so a start held through reset does not begin a game.
- start_rise = start & ~start_q.
- States (game_state encoding): IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, OVER=4. Codes 5-7 are illegal and go to IDLE with reset values.
- stop=1 in every state except PLAY. timer_run=1 only in PLAY.
- IDLE: on start_rise, next cycle: scores=0, winner=00, serve_dir=0, delay counter=0, timer_load=1 for one cycle, state SERVE_WAIT. Otherwise stay.
- SERVE_WAIT: the delay counter increments on each tick_1hz. On the tick where counter==SERVE_TICKS-1: next cycle is PLAY, counter=0, and serve=1 for exactly that first PLAY cycle, with stop=0 in the same cycle.
- PLAY: priority order time_up > miss.
  - time_up=1: next cycle OVER; winner computed from the current scores (greater wins, equal gives 11).
  - Exactly one miss: the opponent's score increments, saturating at WIN_SCORE. serve_dir is set toward the player who missed (miss1 gives 0, miss2 gives 1). Next state POINT.
  - miss1 and miss2 in the same cycle: no score change, serve_dir unchanged, next state POINT.
- POINT lasts exactly one cycle:
  - If score1==WIN_SCORE or score2==WIN_SCORE: go to OVER and latch winner from the updated scores.
  - Else: go to SERVE_WAIT with counter=0.
- OVER: scores and winner held. start_rise performs exactly the IDLE start action (new match).
- Ignored inputs:
  - start_rise in SERVE_WAIT, PLAY and POINT.
  - miss1/miss2 outside PLAY.
  - tick_1hz outside SERVE_WAIT.
- rst asserted in any state, mid-serve or mid-rally: next edge yields reset values; no serve or timer_load pulse is emitted.
- Latency: a miss sampled at edge N shows the updated score and game_state=POINT after edge N. The first SERVE_WAIT cycle follows edge N+1.

Decomposition:
- Shared package pong_pkg holds the state encodings (IDLE..OVER), the winner codes (NONE, P1, P2, DRAW) and the 3-bit state width constant.
- One sub-module: tick_counter (parameter SERVE_TICKS; inputs clk, rst, clr, tick; output done pulse). It implements the serve delay.
- The FSM and score logic stay in game_flow_ctrl.

Test Plan:
- Reset then idle: rst for 2 cycles with start=1 held, then released to 0 → state IDLE, stop=1, scores 0, no transition until a fresh 0→1 on start.
- Serve timing: start_rise, then 2 tick_1hz pulses 100 cycles apart → timer_load pulses once; game_state goes 1 then 2; serve=1 for exactly one cycle coincident with stop falling.
- Scoring: in PLAY pulse miss1 → score2=1, serve_dir=0, POINT for 1 cycle, then SERVE_WAIT; repeat 6 more times → score2=7, state OVER, winner=10.
- Time expiry: score1=3, score2=3, assert time_up in PLAY → OVER, winner=11, timer_run=0. Also assert time_up together with miss2 → OVER with score1 unchanged.
- Simultaneous and ignored events: miss1&miss2 together in PLAY → scores unchanged, POINT then SERVE_WAIT. miss pulses during SERVE_WAIT → no effect.
- Restart and mid-game reset: start_rise in OVER → scores 0, timer_load pulse, SERVE_WAIT. rst during PLAY with score1=4 → IDLE, score1=0, serve=0.
